// File: rtl/axi_lsu_nslave_bridge.sv
// AXI load/store 1-to-N slave bridge: address decode, per-slave ID tracking,
// W-beat routing FIFO, and round-robin R/B return arbitration.
module axi_lsu_nslave_bridge #(
    parameter int M_ID_WIDTH = 8,
    parameter int NSLV       = 2,
    parameter int DW         = 64,
    parameter int IDQ_DEPTH  = 4,
    parameter int WSEL_DEPTH = 4,
    parameter logic [NSLV*32-1:0] REGION_BASE = {{(NSLV-1){32'hEE00_0000}}, 32'h0},
    parameter logic [NSLV*32-1:0] REGION_MASK = {{(NSLV-1){32'hFF00_0000}}, 32'h0}
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   m_arvalid,
    output logic                   m_arready,
    input  logic [M_ID_WIDTH-1:0]  m_arid,
    input  logic [31:0]            m_araddr,
    output logic                   m_rvalid,
    input  logic                   m_rready,
    output logic [DW-1:0]          m_rdata,
    output logic [M_ID_WIDTH-1:0]  m_rid,
    output logic [1:0]             m_rresp,
    output logic                   m_rlast,
    input  logic                   m_awvalid,
    output logic                   m_awready,
    input  logic [M_ID_WIDTH-1:0]  m_awid,
    input  logic [31:0]            m_awaddr,
    input  logic                   m_wvalid,
    output logic                   m_wready,
    output logic                   m_bvalid,
    input  logic                   m_bready,
    output logic [M_ID_WIDTH-1:0]  m_bid,
    output logic [1:0]             m_bresp,
    output logic [NSLV-1:0]        s_arvalid,
    input  logic [NSLV-1:0]        s_arready,
    output logic [NSLV-1:0]        s_awvalid,
    input  logic [NSLV-1:0]        s_awready,
    output logic [NSLV-1:0]        s_wvalid,
    input  logic [NSLV-1:0]        s_wready,
    input  logic [NSLV-1:0]        s_rvalid,
    input  logic [NSLV-1:0]        s_rlast,
    output logic [NSLV-1:0]        s_rready,
    input  logic [NSLV*DW-1:0]     s_rdata,
    input  logic [NSLV*2-1:0]      s_rresp,
    input  logic [NSLV-1:0]        s_bvalid,
    output logic [NSLV-1:0]        s_bready,
    input  logic [NSLV*2-1:0]      s_bresp,
    input  logic [M_ID_WIDTH-1:0]  s0_rid,
    input  logic [M_ID_WIDTH-1:0]  s0_bid,
    output logic                   id_err
);

    localparam int SW  = (NSLV > 2) ? 2 : 1;
    localparam int QPW = $clog2(IDQ_DEPTH);
    localparam int QCW = $clog2(IDQ_DEPTH + 1);
    localparam int WPW = $clog2(WSEL_DEPTH);
    localparam int WCW = $clog2(WSEL_DEPTH + 1);

    // Lowest-numbered matching region wins; no match falls through to slave 0.
    function automatic logic [SW-1:0] decode(input logic [31:0] addr);
        logic [SW-1:0] sel;
        sel = '0;
        for (int k = NSLV - 1; k >= 1; k--) begin
            if ((addr & REGION_MASK[32*k +: 32]) == REGION_BASE[32*k +: 32])
                sel = SW'(k);
        end
        return sel;
    endfunction

    function automatic logic [SW-1:0] rr_next(input logic [SW-1:0] g);
        return (g == SW'(NSLV - 1)) ? '0 : g + 1'b1;
    endfunction

    logic [M_ID_WIDTH-1:0] arq [NSLV][IDQ_DEPTH];
    logic [M_ID_WIDTH-1:0] awq [NSLV][IDQ_DEPTH];
    logic [QPW-1:0]        arq_wr [NSLV];
    logic [QPW-1:0]        arq_rd [NSLV];
    logic [QCW-1:0]        arq_cnt [NSLV];
    logic [QPW-1:0]        awq_wr [NSLV];
    logic [QPW-1:0]        awq_rd [NSLV];
    logic [QCW-1:0]        awq_cnt [NSLV];
    logic [NSLV-1:0]       arq_push, arq_pop, awq_push, awq_pop;
    logic [NSLV-1:0]       arq_empty, awq_empty;

    logic [SW-1:0]         wq [WSEL_DEPTH];
    logic [WPW-1:0]        wq_wr, wq_rd;
    logic [WCW-1:0]        wq_cnt;
    logic                  wq_full, wq_empty;

    logic [SW-1:0]         ar_sel, aw_sel, w_tgt;
    logic                  ar_blk, aw_blk, ar_hs, aw_hs, w_hs, w_route;
    logic [SW-1:0]         r_gnt, r_ptr, r_lock_id, b_gnt, b_ptr;
    logic                  r_lock, r_hs, b_hs, err_set;

    // Address decode and flow control; blocking never looks at slave ready.
    always_comb begin
        ar_sel    = decode(m_araddr);
        aw_sel    = decode(m_awaddr);
        wq_full   = (wq_cnt == WCW'(WSEL_DEPTH));
        wq_empty  = (wq_cnt == '0);
        ar_blk    = (ar_sel != '0) && (arq_cnt[ar_sel] == QCW'(IDQ_DEPTH));
        aw_blk    = ((aw_sel != '0) && (awq_cnt[aw_sel] == QCW'(IDQ_DEPTH))) || wq_full;
        m_arready = s_arready[ar_sel] & ~ar_blk;
        m_awready = s_awready[aw_sel] & ~aw_blk;
        ar_hs     = m_arvalid & m_arready;
        aw_hs     = m_awvalid & m_awready;
        w_route   = !wq_empty || aw_hs;
        w_tgt     = !wq_empty ? wq[wq_rd] : aw_sel;
        m_wready  = w_route & s_wready[w_tgt];
        w_hs      = m_wvalid & m_wready;
    end

    // R grant: locked mid-burst, otherwise round-robin from r_ptr.
    always_comb begin
        logic          found;
        logic [SW-1:0] idx;
        found = 1'b0;
        idx   = '0;
        r_gnt = r_ptr;
        if (r_lock) begin
            r_gnt = r_lock_id;
        end else begin
            for (int i = 0; i < NSLV; i++) begin
                idx = SW'((int'(r_ptr) + i) % NSLV);
                if (!found && s_rvalid[idx]) begin
                    r_gnt = idx;
                    found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        logic          found;
        logic [SW-1:0] idx;
        found = 1'b0;
        idx   = '0;
        b_gnt = b_ptr;
        for (int i = 0; i < NSLV; i++) begin
            idx = SW'((int'(b_ptr) + i) % NSLV);
            if (!found && s_bvalid[idx]) begin
                b_gnt = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        m_rvalid = s_rvalid[r_gnt];
        m_rdata  = s_rdata[r_gnt*DW +: DW];
        m_rresp  = s_rresp[r_gnt*2 +: 2];
        m_rlast  = s_rlast[r_gnt];
        r_hs     = m_rvalid & m_rready;
        m_bvalid = s_bvalid[b_gnt];
        m_bresp  = s_bresp[b_gnt*2 +: 2];
        b_hs     = m_bvalid & m_bready;
        if (r_gnt == '0)             m_rid = s0_rid;
        else if (arq_cnt[r_gnt] != '0) m_rid = arq[r_gnt][arq_rd[r_gnt]];
        else                         m_rid = '0;
        if (b_gnt == '0)             m_bid = s0_bid;
        else if (awq_cnt[b_gnt] != '0) m_bid = awq[b_gnt][awq_rd[b_gnt]];
        else                         m_bid = '0;
    end

    always_comb begin
        s_arvalid = '0;
        s_awvalid = '0;
        s_wvalid  = '0;
        s_rready  = '0;
        s_bready  = '0;
        arq_push  = '0;
        arq_pop   = '0;
        awq_push  = '0;
        awq_pop   = '0;
        arq_empty = '0;
        awq_empty = '0;
        for (int k = 0; k < NSLV; k++) begin
            s_arvalid[k] = m_arvalid && (ar_sel == SW'(k)) && !ar_blk;
            s_awvalid[k] = m_awvalid && (aw_sel == SW'(k)) && !aw_blk;
            s_wvalid[k]  = m_wvalid && w_route && (w_tgt == SW'(k));
            s_rready[k]  = m_rready && (r_gnt == SW'(k));
            s_bready[k]  = m_bready && (b_gnt == SW'(k));
            if (k != 0) begin
                arq_empty[k] = (arq_cnt[k] == '0);
                awq_empty[k] = (awq_cnt[k] == '0);
                arq_push[k]  = ar_hs && (ar_sel == SW'(k));
                awq_push[k]  = aw_hs && (aw_sel == SW'(k));
                arq_pop[k]   = r_hs && m_rlast && (r_gnt == SW'(k)) && !arq_empty[k];
                awq_pop[k]   = b_hs && (b_gnt == SW'(k)) && !awq_empty[k];
            end
        end
        err_set = |(s_rvalid & arq_empty) || |(s_bvalid & awq_empty);
    end

    // Queue storage carries no reset; only pointers and counts are cleared.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NSLV; k++) begin
            if (arq_push[k]) arq[k][arq_wr[k]] <= m_arid;
            if (awq_push[k]) awq[k][awq_wr[k]] <= m_awid;
        end
        if (aw_hs) wq[wq_wr] <= aw_sel;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NSLV; k++) begin
                arq_wr[k]  <= '0;
                arq_rd[k]  <= '0;
                arq_cnt[k] <= '0;
                awq_wr[k]  <= '0;
                awq_rd[k]  <= '0;
                awq_cnt[k] <= '0;
            end
            wq_wr     <= '0;
            wq_rd     <= '0;
            wq_cnt    <= '0;
            r_lock    <= 1'b0;
            r_lock_id <= '0;
            r_ptr     <= '0;
            b_ptr     <= '0;
            id_err    <= 1'b0;
        end else begin
            for (int k = 0; k < NSLV; k++) begin
                if (arq_push[k]) arq_wr[k] <= arq_wr[k] + 1'b1;
                if (arq_pop[k])  arq_rd[k] <= arq_rd[k] + 1'b1;
                if (arq_push[k] && !arq_pop[k])      arq_cnt[k] <= arq_cnt[k] + 1'b1;
                else if (!arq_push[k] && arq_pop[k]) arq_cnt[k] <= arq_cnt[k] - 1'b1;
                if (awq_push[k]) awq_wr[k] <= awq_wr[k] + 1'b1;
                if (awq_pop[k])  awq_rd[k] <= awq_rd[k] + 1'b1;
                if (awq_push[k] && !awq_pop[k])      awq_cnt[k] <= awq_cnt[k] + 1'b1;
                else if (!awq_push[k] && awq_pop[k]) awq_cnt[k] <= awq_cnt[k] - 1'b1;
            end
            // Bypass (empty FIFO, AW and W together) pushes and pops in one cycle.
            if (aw_hs) wq_wr <= wq_wr + 1'b1;
            if (w_hs)  wq_rd <= wq_rd + 1'b1;
            if (aw_hs && !w_hs)      wq_cnt <= wq_cnt + 1'b1;
            else if (!aw_hs && w_hs) wq_cnt <= wq_cnt - 1'b1;
            if (r_hs) begin
                r_lock    <= ~m_rlast;
                r_lock_id <= r_gnt;
                r_ptr     <= rr_next(r_gnt);
            end
            if (b_hs) b_ptr <= rr_next(b_gnt);
            if (err_set) id_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_axi_lsu_nslave_bridge.sv
// Directed bench for axi_lsu_nslave_bridge (NSLV=2, slave 1 at 0xEE000000/0xFF000000).
module tb_axi_lsu_nslave_bridge;

    logic         clk = 1'b0;
    logic         reset;
    logic         m_arvalid, m_arready;
    logic [7:0]   m_arid;
    logic [31:0]  m_araddr;
    logic         m_rvalid, m_rready;
    logic [63:0]  m_rdata;
    logic [7:0]   m_rid;
    logic [1:0]   m_rresp;
    logic         m_rlast;
    logic         m_awvalid, m_awready;
    logic [7:0]   m_awid;
    logic [31:0]  m_awaddr;
    logic         m_wvalid, m_wready;
    logic         m_bvalid, m_bready;
    logic [7:0]   m_bid;
    logic [1:0]   m_bresp;
    logic [1:0]   s_arvalid, s_arready, s_awvalid, s_awready, s_wvalid, s_wready;
    logic [1:0]   s_rvalid, s_rlast, s_rready, s_bvalid, s_bready;
    logic [127:0] s_rdata;
    logic [3:0]   s_rresp, s_bresp;
    logic [7:0]   s0_rid, s0_bid;
    logic         id_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axi_lsu_nslave_bridge #(
        .M_ID_WIDTH(8), .NSLV(2), .DW(64), .IDQ_DEPTH(4), .WSEL_DEPTH(4),
        .REGION_BASE(64'hEE00_0000_0000_0000),
        .REGION_MASK(64'hFF00_0000_0000_0000)
    ) dut (
        .clk(clk), .reset(reset),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arid(m_arid), .m_araddr(m_araddr),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rid(m_rid),
        .m_rresp(m_rresp), .m_rlast(m_rlast),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awid(m_awid), .m_awaddr(m_awaddr),
        .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bid(m_bid), .m_bresp(m_bresp),
        .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_rvalid(s_rvalid), .s_rlast(s_rlast), .s_rready(s_rready),
        .s_rdata(s_rdata), .s_rresp(s_rresp),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
        .s0_rid(s0_rid), .s0_bid(s0_bid), .id_err(id_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        m_arvalid = 0; m_arid = 0; m_araddr = 0; m_rready = 0;
        m_awvalid = 0; m_awid = 0; m_awaddr = 0; m_wvalid = 0; m_bready = 0;
        s_arready = 0; s_awready = 0; s_wready = 0;
        s_rvalid = 0; s_rlast = 0; s_rdata = '0; s_rresp = '0;
        s_bvalid = 0; s_bresp = '0; s0_rid = 8'h33; s0_bid = 8'h44;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        s_arready = 2'b11; s_awready = 2'b11; s_wready = 2'b11;
        #1;
        check("rst_arready", m_arready, 1);
        check("rst_awready", m_awready, 1);
        check("rst_wready", m_wready, 0);
        check("rst_rvalid", m_rvalid, 0);
        check("rst_bvalid", m_bvalid, 0);
        check("rst_id_err", id_err, 0);

        // Single read to slave 1
        m_arvalid = 1; m_araddr = 32'hEE00_0010; m_arid = 8'h5A;
        #1;
        check("ar1_s_arvalid", s_arvalid, 2'b10);
        check("ar1_arready", m_arready, 1);
        tick();
        m_arvalid = 0; s_rvalid = 2'b10; s_rlast = 2'b10;
        s_rdata = {64'hD1, 64'h0}; m_rready = 1;
        #1;
        check("r1_rvalid", m_rvalid, 1);
        check("r1_rid", m_rid, 8'h5A);
        check("r1_rdata", m_rdata, 64'hD1);
        check("r1_s_rready", s_rready, 2'b10);
        tick();
        s_rvalid = 0; s_rlast = 0;

        // Fill AR-ID queue[1]; 5th AR must stall until a pop
        for (int i = 1; i <= 4; i++) begin
            m_arvalid = 1; m_araddr = 32'hEE00_0020; m_arid = 8'(i);
            #1;
            check("fill_arready", m_arready, 1);
            tick();
        end
        m_arid = 8'h05;
        #1;
        check("full_arready", m_arready, 0);
        check("full_s_arvalid", s_arvalid, 2'b00);
        s_rvalid = 2'b10; s_rlast = 2'b10;
        #1;
        check("full_pop_rid", m_rid, 8'h01);
        tick();
        s_rvalid = 0;
        #1;
        check("after_pop_arready", m_arready, 1);
        tick();
        m_arvalid = 0; s_rvalid = 2'b10; s_rlast = 2'b10;
        for (int i = 2; i <= 5; i++) begin
            #1;
            check("drain_rid", m_rid, 64'(i));
            tick();
        end
        s_rvalid = 0; s_rlast = 0;

        // R round-robin with burst lock
        m_arvalid = 1; m_araddr = 32'hEE00_0000; m_arid = 8'h77;
        tick();
        m_arid = 8'h78;
        tick();
        m_arvalid = 0;
        s_rvalid = 2'b11; s_rlast = 2'b00; s_rdata = {64'hB0, 64'hA0}; m_rready = 1;
        #1;
        check("rr_first_s0", s_rready, 2'b01);
        check("rr_first_rdata", m_rdata, 64'hA0);
        check("rr_first_rid", m_rid, 8'h33);
        tick();
        s_rlast = 2'b01; s_rdata = {64'hB0, 64'hA1};
        #1;
        check("rr_lock_s0", s_rready, 2'b01);
        check("rr_lock_rdata", m_rdata, 64'hA1);
        tick();
        s_rlast = 2'b00; s_rdata = {64'hB0, 64'hA2};
        #1;
        check("rr_then_s1", s_rready, 2'b10);
        check("rr_s1_rid", m_rid, 8'h77);
        check("rr_s1_rdata", m_rdata, 64'hB0);
        tick();
        s_rlast = 2'b10; s_rdata = {64'hB1, 64'hA2};
        #1;
        check("rr_lock_s1", s_rready, 2'b10);
        check("rr_s1_rlast", m_rlast, 1);
        tick();
        s_rlast = 2'b11;
        #1;
        check("rr_wrap_s0", s_rready, 2'b01);
        check("rr_wrap_rdata", m_rdata, 64'hA2);
        tick();
        s_rvalid = 2'b10; s_rlast = 2'b10;
        #1;
        check("rr_last_rid", m_rid, 8'h78);
        tick();
        s_rvalid = 0; s_rlast = 0; m_rready = 0;

        // W routing through the FIFO, then bypass
        m_awvalid = 1; m_awaddr = 32'h0000_1000; m_awid = 8'h11;
        #1;
        check("aw0_awready", m_awready, 1);
        tick();
        m_awaddr = 32'hEE00_0000; m_awid = 8'h22;
        tick();
        m_awvalid = 0; m_wvalid = 1;
        #1;
        check("w1_s_wvalid", s_wvalid, 2'b01);
        check("w1_wready", m_wready, 1);
        tick();
        #1;
        check("w2_s_wvalid", s_wvalid, 2'b10);
        tick();
        #1;
        check("wempty_wready", m_wready, 0);
        check("wempty_s_wvalid", s_wvalid, 2'b00);
        m_awvalid = 1; m_awaddr = 32'hEE00_0004; m_awid = 8'h23;
        #1;
        check("byp_s_wvalid", s_wvalid, 2'b10);
        check("byp_wready", m_wready, 1);
        check("byp_s_awvalid", s_awvalid, 2'b10);
        tick();
        m_awvalid = 0;
        #1;
        check("byp_cnt0_wready", m_wready, 0);
        m_wvalid = 0;

        // B round-robin
        s_bvalid = 2'b11; s_bresp = {2'b10, 2'b00}; m_bready = 1;
        #1;
        check("b_first_bid", m_bid, 8'h44);
        check("b_first_bready", s_bready, 2'b01);
        tick();
        #1;
        check("b_second_bid", m_bid, 8'h22);
        check("b_second_bresp", m_bresp, 2'b10);
        check("b_second_bready", s_bready, 2'b10);
        tick();
        #1;
        check("b_third_bready", s_bready, 2'b01);
        tick();
        s_bvalid = 2'b10;
        #1;
        check("b_fourth_bid", m_bid, 8'h23);
        tick();
        s_bvalid = 0;

        // Orphan B response raises sticky id_err
        m_bready = 0; s_bvalid = 2'b10;
        #1;
        check("orphan_bvalid", m_bvalid, 1);
        check("orphan_bid", m_bid, 8'h00);
        check("orphan_err_pre", id_err, 0);
        tick();
        check("orphan_err_set", id_err, 1);
        s_bvalid = 0;
        repeat (3) tick();
        check("orphan_err_hold", id_err, 1);

        // Reset with 3 W-route entries pending
        m_awvalid = 1; m_awaddr = 32'h0;
        repeat (3) tick();
        m_awvalid = 0; m_wvalid = 1;
        #1;
        check("pend_wready", m_wready, 1);
        reset = 1;
        tick();
        reset = 0;
        #1;
        check("rst2_wready", m_wready, 0);
        check("rst2_s_wvalid", s_wvalid, 2'b00);
        check("rst2_id_err", id_err, 0);
        check("rst2_awready", m_awready, 1);
        m_wvalid = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_lsu_nslave_bridge.md
AXI_LSU_NSLAVE_BRIDGE -- requirements
Module: axi_lsu_nslave_bridge

Interface
REQ-001 The block SHALL have parameter M_ID_WIDTH, default 8, meaning the master and slave-0 ID width.
REQ-002 The block SHALL have parameter NSLV, default 2, legal 2..4, meaning the number of slave ports.
REQ-003 The block SHALL have parameter DW, default 64, meaning the read data width.
REQ-004 The block SHALL have parameter IDQ_DEPTH, default 4, power of 2, meaning the per-slave ID queue depth.
REQ-005 The block SHALL have parameter WSEL_DEPTH, default 4, power of 2, meaning the depth of the W-route FIFO.
REQ-006 The block SHALL have parameters REGION_BASE and REGION_MASK, NSLV*32 bits each, meaning the decode base and mask for slave k in bits [32k+31:32k]; entry 0 is unused.
REQ-007 The block SHALL have the following ports:
- clk  in  1  clock; one clock only.
- reset  in  1  synchronous, active-high reset.
- m_arvalid/m_arready  in/out  1  AR handshake.
- m_arid  in  M_ID_WIDTH.
- m_araddr  in  32.
- m_rvalid/m_rready  out/in  1.
- m_rdata  out  DW.
- m_rid  out  M_ID_WIDTH.
- m_rresp  out  2.
- m_rlast  out  1.
- m_awvalid/m_awready  in/out  1.
- m_awid  in  M_ID_WIDTH.
- m_awaddr  in  32.
- m_wvalid/m_wready  in/out  1.
- m_bvalid/m_bready  out/in  1.
- m_bid  out  M_ID_WIDTH.
- m_bresp  out  2.
- s_arvalid/s_arready, s_awvalid/s_awready, s_wvalid/s_wready  out/in  NSLV each  per-slave handshakes.
- s_rvalid, s_rlast  in  NSLV.
- s_rready  out  NSLV.
- s_rdata  in  NSLV*DW.
- s_rresp  in  NSLV*2.
- s_bvalid  in  NSLV.
- s_bready  out  NSLV.
- s_bresp  in  NSLV*2.
- s0_rid, s0_bid  in  M_ID_WIDTH  slave-0 IDs.
- id_err  out  1  sticky protocol error flag.

Function
REQ-008 The AR and AW decode SHALL select the lowest k >= 1 with (addr & MASK[k]) == BASE[k], and otherwise select slave 0.
REQ-009 s_arvalid[k] SHALL be m_arvalid & sel==k & ~blk, and m_arready SHALL be s_arready[sel] & ~blk.
- blk = (sel>=1 & AR-ID queue[sel] full).
- blk SHALL never be derived from s_arready (no combinational loop through valid).
REQ-010 AW SHALL follow REQ-009, with blk additionally asserted when the W-route FIFO is full.
REQ-011 Each AW handshake SHALL push sel into the W-route FIFO, and each W handshake SHALL pop it; W beats are single-beat.
REQ-012 W routing SHALL be as follows:
- FIFO non-empty: route W to the head entry.
- FIFO empty and AW handshaking in the same cycle: bypass, route W to the AW sel.
- FIFO empty and no AW handshake: m_wready=0 and all s_wvalid=0.
REQ-013 Simultaneous W-route FIFO push and pop SHALL leave the count unchanged; pointers wrap modulo WSEL_DEPTH.
REQ-014 For k >= 1, an AR handshake SHALL push m_arid into AR-ID queue[k], and an AW handshake SHALL push m_awid into AW-ID queue[k].
REQ-015 For k >= 1, an R handshake from slave k with s_rlast=1 SHALL pop AR-ID queue[k], and a B handshake from slave k SHALL pop AW-ID queue[k].
REQ-016 m_rid SHALL be s0_rid for slave 0 and the AR-ID queue[k] head otherwise; m_bid SHALL be derived the same way from s0_bid and the AW-ID queue.
REQ-017 R arbitration SHALL be round-robin among s_rvalid, starting after the last granted slave, with reset pointer 0.
REQ-018 Once a non-last R beat is granted, the R grant SHALL lock to that slave until its rlast handshake.
REQ-019 B arbitration SHALL be round-robin, re-arbitrated every handshake, with an independent pointer.
REQ-020 The R and B paths SHALL behave as follows:
- m_rvalid = s_rvalid[grant]; m_rdata/rresp/rlast are muxed from grant.
- s_rready[k] = m_rready & grant==k.
- B paths are identical in form.
- Zero cycles of latency; purely combinational muxing.
REQ-021 id_err SHALL set when slave k>=1 presents rvalid or bvalid while its matching ID queue is empty, and SHALL hold until reset.
- m_rid/m_bid SHALL be 0 in that case.

Reset
REQ-022 While reset is high at a clk edge, the following SHALL clear:
- all FIFO/queue counts and pointers;
- the R lock;
- both round-robin pointers (to 0);
- id_err (to 0).
REQ-023 After reset, m_arready/m_awready SHALL follow REQ-009/010 with empty queues, and m_wready, m_rvalid and m_bvalid SHALL be 0 absent slave valids.
REQ-024 Reset asserted mid-burst SHALL discard all in-flight routing and ID state, with no drain.

Verification
REQ-025 The bench SHALL cover the following directed scenarios:
- NSLV=2, BASE[1]=0xEE000000, MASK[1]=0xFF000000; AR 0xEE000010 id 0x5A, then slave 1 returns 1 beat rlast -> s_arvalid=2'b10, m_rid=0x5A, queue[1] empty afterwards.
- IDQ_DEPTH=4; 4 AR to slave 1 with no R returned -> 5th AR sees m_arready=0 with s_arready[1]=1; after one rlast pop, 5th accepted next cycle.
- AW to s0, AW to s1, then W, W -> first W to slave 0, second to slave 1; AW+W same cycle with empty FIFO -> bypass to AW target, count stays 0.
- Slave 0 and slave 1 both rvalid, 2-beat bursts -> grant s0 both beats (locked), then s1; next simultaneous request grants s0 after s1 (round-robin).
- Slave 1 bvalid with AW-ID queue empty -> id_err=1 next cycle, stays 1 until reset, m_bid=0.
- Reset pulsed with 3 W-route entries pending -> count 0, m_wready=0 next cycle with no AW.
